rate_timer: RTL and testbench

RATE_TIMER -- requirements
Module: rate_timer

---
 rtl/rate_timer_pkg.sv | 27 ++
 rtl/rate_timer_dffr.sv | 17 +
 rtl/rate_timer_tick_counter.sv | 60 ++++++
 rtl/rate_timer.sv | 92 +++++++++
 tb/tb_rate_timer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rate_timer_pkg.sv
// Shared defaults and helpers for the rate timer and its master FSM.
// Period for level k is BASE_PERIOD << (SPEEDS-1-k) clock cycles.
package rate_timer_pkg;

  localparam int RT_SPEEDS      = 4;
  localparam int RT_BASE_PERIOD = 2;
  localparam int RT_RESET_IDX   = 1;

  typedef enum logic [1:0] {
    SHIFT_NONE,
    SHIFT_LEFT,
    SHIFT_RIGHT,
    SHIFT_RECOVER
  } shift_e;

  function automatic int rt_period(input int speeds, input int base, input int k);
    return base << (speeds - 1 - k);
  endfunction

  // Counter must hold P(0)-1, the longest reload value.
  function automatic int rt_cnt_w(input int speeds, input int base);
    int p0;
    p0 = rt_period(speeds, base, 0);
    return ($clog2(p0) < 1) ? 1 : $clog2(p0);
  endfunction

endpackage

// File: rtl/rate_timer_dffr.sv
// Codebase register primitive: D flop with synchronous active-high reset r.
module dffr #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         r,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (r) q <= RST_VAL;
    else   q <= d;
  end

endmodule

// File: rtl/rate_timer_tick_counter.sv
// Reloadable down-counter producing a registered one-cycle tick at terminal count.
// The reload value is latched on load, so the period follows the last requested level.
module tick_counter #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_CNT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             run,
  output logic             tick
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             tick_q, tick_d;

  // A load wins over terminal count, so a level change suppresses a pending tick.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
    end else if (run) begin
      if (count_q == '0) begin
        count_d = reload_q;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  dffr #(.W(CNT_W), .RST_VAL(RST_CNT)) u_count_reg (
    .clk (clk),
    .r   (rst),
    .d   (count_d),
    .q   (count_q)
  );

  dffr #(.W(CNT_W), .RST_VAL(RST_CNT)) u_reload_reg (
    .clk (clk),
    .r   (rst),
    .d   (reload_d),
    .q   (reload_q)
  );

  dffr #(.W(1), .RST_VAL(1'b0)) u_tick_reg (
    .clk (clk),
    .r   (rst),
    .d   (tick_d),
    .q   (tick_q)
  );

  assign tick = tick_q;

endmodule

// File: rtl/rate_timer.sv
// Multi-speed tick generator: one-hot speed register with saturating shifts,
// driving a reloadable tick counter whose period halves per level step.
module rate_timer
  import rate_timer_pkg::*;
#(
  parameter int SPEEDS      = RT_SPEEDS,
  parameter int BASE_PERIOD = RT_BASE_PERIOD,
  parameter int RESET_IDX   = RT_RESET_IDX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shift_left,
  input  logic              shift_right,
  input  logic              run,
  output logic [SPEEDS-1:0] speed,
  output logic              tick,
  output logic              at_max,
  output logic              at_min
);

  localparam int                CNT_W     = rt_cnt_w(SPEEDS, BASE_PERIOD);
  localparam logic [SPEEDS-1:0] SPEED_RST = SPEEDS'(1) << RESET_IDX;
  localparam logic [CNT_W-1:0]  CNT_RST   =
    CNT_W'(rt_period(SPEEDS, BASE_PERIOD, RESET_IDX) - 1);

  logic [SPEEDS-1:0] speed_q, speed_d;
  logic              legal;
  int                ones;
  shift_e            shift_sel;
  logic              load;
  logic [CNT_W-1:0]  load_val;

  always_comb begin
    ones = 0;
    for (int k = 0; k < SPEEDS; k++) begin
      ones = ones + int'(speed_q[k]);
    end
    legal = (ones == 1);
  end

  // Simultaneous or saturated requests fall through to SHIFT_NONE: no reload.
  always_comb begin
    shift_sel = SHIFT_NONE;
    if (!legal) begin
      shift_sel = SHIFT_RECOVER;
    end else if (shift_left && !shift_right && !speed_q[SPEEDS-1]) begin
      shift_sel = SHIFT_LEFT;
    end else if (shift_right && !shift_left && !speed_q[0]) begin
      shift_sel = SHIFT_RIGHT;
    end
  end

  always_comb begin
    speed_d = speed_q;
    case (shift_sel)
      SHIFT_LEFT:    speed_d = speed_q << 1;
      SHIFT_RIGHT:   speed_d = speed_q >> 1;
      SHIFT_RECOVER: speed_d = SPEED_RST;
      default:       speed_d = speed_q;
    endcase
  end

  assign load = (shift_sel != SHIFT_NONE);

  always_comb begin
    load_val = '0;
    for (int k = 0; k < SPEEDS; k++) begin
      if (speed_d[k]) load_val = CNT_W'(rt_period(SPEEDS, BASE_PERIOD, k) - 1);
    end
  end

  dffr #(.W(SPEEDS), .RST_VAL(SPEED_RST)) u_speed_reg (
    .clk (clock),
    .r   (reset),
    .d   (speed_d),
    .q   (speed_q)
  );

  tick_counter #(.CNT_W(CNT_W), .RST_CNT(CNT_RST)) u_tick_counter (
    .clk      (clock),
    .rst      (reset),
    .load     (load),
    .load_val (load_val),
    .run      (run),
    .tick     (tick)
  );

  assign speed  = speed_q;
  assign at_max = speed_q[SPEEDS-1];
  assign at_min = speed_q[0];

endmodule

// File: tb/tb_rate_timer.sv
// Randomised and directed bench for rate_timer against a behavioural model that
// counts elapsed running cycles and fires when they reach the level's period.
module tb_rate_timer;

  localparam int S = 4;
  localparam int B = 2;
  localparam int R = 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         shift_left = 1'b0;
  logic         shift_right = 1'b0;
  logic         run = 1'b0;
  logic [S-1:0] speed;
  logic         tick;
  logic         at_max;
  logic         at_min;

  rate_timer #(.SPEEDS(S), .BASE_PERIOD(B), .RESET_IDX(R)) dut (
    .clock       (clock),
    .reset       (reset),
    .shift_left  (shift_left),
    .shift_right (shift_right),
    .run         (run),
    .speed       (speed),
    .tick        (tick),
    .at_max      (at_max),
    .at_min      (at_min)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [S-1:0] speed;
    logic         tick;
    logic         mx;
    logic         mn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dut_ticks = 0;
  bit   done = 1'b0;

  int   m_idx;
  int   m_el;
  logic m_tick;

  function automatic int period(input int k);
    return B * (1 << (S - 1 - k));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic model_step(input logic rst, input logic sl, input logic sr, input logic rn);
    int   nidx;
    exp_t e;
    if (rst) begin
      m_idx  = R;
      m_el   = 0;
      m_tick = 1'b0;
    end else begin
      nidx = m_idx;
      if (sl && !sr && m_idx < S - 1) nidx = m_idx + 1;
      else if (sr && !sl && m_idx > 0) nidx = m_idx - 1;
      if (nidx != m_idx) begin
        m_idx  = nidx;
        m_el   = 0;
        m_tick = 1'b0;
      end else if (rn) begin
        m_el++;
        if (m_el == period(m_idx)) begin
          m_tick = 1'b1;
          m_el   = 0;
        end else begin
          m_tick = 1'b0;
        end
      end else begin
        m_tick = 1'b0;
      end
    end
    e.speed = S'(1) << m_idx;
    e.tick  = m_tick;
    e.mx    = (m_idx == S - 1);
    e.mn    = (m_idx == 0);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic sl, input logic sr, input logic rn);
    @(negedge clock);
    reset       = rst;
    shift_left  = sl;
    shift_right = sr;
    run         = rn;
    model_step(rst, sl, sr, rn);
  endtask

  task automatic run_n(input int n, input logic rn);
    repeat (n) drive(1'b0, 1'b0, 1'b0, rn);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clock);
      #1;
      cyc++;
      if (tick === 1'b1) dut_ticks++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at cycle %0d: got no expectation, expected one", cyc);
      end else begin
        e = exp_q.pop_front();
        check("speed", 32'(speed), 32'(e.speed));
        check("tick", 32'(tick), 32'(e.tick));
        check("at_max", 32'(at_max), 32'(e.mx));
        check("at_min", 32'(at_min), 32'(e.mn));
      end
    end
  end

  initial begin
    int   t0;
    logic rst, sl, sr, rn;

    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    t0 = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run_n(40, 1'b1);
    settle();
    check("ticks_in_first_40", 32'(dut_ticks - t0), 32'd5);

    // Climb to the fastest level, then a saturated shift_left must not disturb cadence.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    run_n(3, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    run_n(3, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    run_n(6, 1'b1);
    settle();
    check("at_max_after_3_left", 32'(at_max), 32'd1);
    t0 = dut_ticks;
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    run_n(19, 1'b1);
    settle();
    check("ticks_20_at_max", 32'(dut_ticks - t0), 32'd10);

    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    check("at_min_after_1_right", 32'(at_min), 32'd1);
    run_n(2, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    run_n(2, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    t0 = dut_ticks;
    run_n(32, 1'b1);
    settle();
    check("ticks_32_at_min", 32'(dut_ticks - t0), 32'd2);

    drive(1'b1, 1'b0, 1'b0, 1'b1);
    run_n(3, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    run_n(3, 1'b1);
    settle();
    check("speed_after_both", 32'(speed), 32'h2);
    run_n(1, 1'b1);
    settle();
    check("tick_original_schedule", 32'(tick), 32'd1);

    drive(1'b1, 1'b0, 1'b0, 1'b1);
    run_n(7, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    check("tick_shift_at_zero", 32'(tick), 32'd0);
    run_n(3, 1'b1);
    settle();
    check("tick_before_new_period", 32'(tick), 32'd0);
    run_n(1, 1'b1);
    settle();
    check("tick_4_after_shift", 32'(tick), 32'd1);

    drive(1'b1, 1'b0, 1'b0, 1'b1);
    run_n(3, 1'b1);
    run_n(5, 1'b0);
    run_n(4, 1'b1);
    settle();
    check("tick_not_early_after_pause", 32'(tick), 32'd0);
    run_n(1, 1'b1);
    settle();
    check("tick_delayed_by_pause", 32'(tick), 32'd1);
    run_n(3, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    t0 = dut_ticks;
    run_n(7, 1'b1);
    settle();
    check("no_tick_7_after_reset", 32'(dut_ticks - t0), 32'd0);
    run_n(1, 1'b1);
    settle();
    check("tick_8_after_reset", 32'(tick), 32'd1);
    check("speed_after_reset", 32'(speed), 32'h2);

    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      sl  = ($urandom_range(0, 15) == 0);
      sr  = ($urandom_range(0, 15) == 0);
      rn  = ($urandom_range(0, 9) != 0);
      drive(rst, sl, sr, rn);
    end
    settle();
    done = 1'b1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
